// File: rtl/i2c_seq_pkg.sv
// rtl/i2c_seq_pkg.sv - shared states, result codes and status-bit layout for the I2C transfer sequencer
package i2c_seq_pkg;

  // Sequencer states
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_CFG_DIV   = 3'd1;
  localparam logic [2:0] ST_CFG_WLEN  = 3'd2;
  localparam logic [2:0] ST_CFG_RLEN  = 3'd3;
  localparam logic [2:0] ST_CFG_START = 3'd4;
  localparam logic [2:0] ST_XFER      = 3'd5;
  localparam logic [2:0] ST_CLEAR     = 3'd6;
  localparam logic [2:0] ST_DONE      = 3'd7;

  // Result codes reported with done
  localparam logic [2:0] RES_OK       = 3'd0;
  localparam logic [2:0] RES_NACK     = 3'd1;
  localparam logic [2:0] RES_ARB_LOST = 3'd2;
  localparam logic [2:0] RES_TIMEOUT  = 3'd3;
  localparam logic [2:0] RES_BAD_REQ  = 3'd4;

  // Bit positions inside reg_status_wdata
  localparam int STAT_STOP_BIT      = 0;
  localparam int STAT_DIN_FULL_BIT  = 1;
  localparam int STAT_DIN_EMPTY_BIT = 2;
  localparam int STAT_DOUT_FULL_BIT = 3;
  localparam int STAT_ACK_BIT       = 4;
  localparam int STAT_NACK_BIT      = 5;

  // Status word that acknowledges one received byte: din_full is cleared,
  // flags we can read back are written unchanged, the rest stay 0.
  function automatic logic [5:0] status_rx_clear(input logic nack,
                                                 input logic dout_full,
                                                 input logic stop);
    logic [5:0] s;
    s = '0;
    s[STAT_NACK_BIT]      = nack;
    s[STAT_DOUT_FULL_BIT] = dout_full;
    s[STAT_STOP_BIT]      = stop;
    s[STAT_DIN_FULL_BIT]  = 1'b0;
    return s;
  endfunction

endpackage

// File: rtl/i2c_seq_timeout.sv
// rtl/i2c_seq_timeout.sv - saturating progress timeout counter for the transfer phase
module i2c_seq_timeout
  import i2c_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic expire
);

  localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] count;

  // Count idle cycles while enabled; any progress restarts, the count holds at the limit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (!enable || clear) begin
      count <= '0;
    end else if (count != LIMIT) begin
      count <= count + CW'(1);
    end
  end

  // A zero limit disables expiry altogether
  assign expire = (TIMEOUT_CYCLES != 0) && enable && (count == LIMIT);

endmodule

// File: rtl/i2c_transfer_sequencer.sv
// rtl/i2c_transfer_sequencer.sv - sequences one I2C master transaction through the core register interface
module i2c_transfer_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [CNT_W-1:0] req_wlen,
  input  logic [CNT_W-1:0] req_rlen,
  input  logic [15:0]      req_clkdiv,
  input  logic             req_packet_type,
  input  logic             tx_valid,
  input  logic [7:0]       tx_data,
  output logic             tx_ready,
  output logic             rx_valid,
  output logic [7:0]       rx_data,
  input  logic             rx_ready,
  output logic             done,
  output logic [2:0]       result,
  output logic [31:0]      reg_wdata,
  output logic             reg_data_out_we,
  output logic             reg_read_length_we,
  output logic             reg_write_length_we,
  output logic             reg_clk_divider_we,
  output logic             reg_config_we,
  output logic             reg_status_we,
  output logic             reg_start,
  output logic             reg_packet_type,
  output logic             reg_fifo_enable,
  output logic [5:0]       reg_status_wdata,
  input  logic             stat_stop,
  input  logic             stat_din_full,
  input  logic             stat_dout_full,
  input  logic             stat_slave_nack,
  input  logic             stat_arb_loss,
  input  logic [7:0]       stat_data_in
);

  logic [2:0]       state;
  logic [CNT_W-1:0] wlen_q;
  logic [CNT_W-1:0] rlen_q;
  logic [15:0]      clkdiv_q;
  logic             ptype_q;
  logic [CNT_W-1:0] wcnt;
  logic [CNT_W-1:0] rcnt;
  logic [2:0]       res_q;
  logic             rx_valid_q;
  logic [7:0]       rx_data_q;
  logic             dout_prev;
  logic             status_prev;
  logic             clr_pend;
  logic [4:0]       flags_prev;

  logic [4:0] flags;
  logic       in_xfer;
  logic       expire;
  logic       fault;
  logic       finish;
  logic       leave;
  logic       tx_fire;
  logic       rx_accept;
  logic       clr_want;
  logic       status_rx;
  logic       rx_capture;
  logic       progress;

  assign flags   = {stat_stop, stat_din_full, stat_dout_full, stat_slave_nack, stat_arb_loss};
  assign in_xfer = (state == ST_XFER);

  // Abort causes block any new core traffic in the cycle they are seen
  assign fault  = stat_arb_loss || stat_slave_nack || expire;
  assign finish = stat_stop && (wcnt == wlen_q) && (rcnt == rlen_q);
  assign leave  = in_xfer && (fault || finish);

  // The previous-cycle data_out write gap gives dout_full time to reflect the last byte
  assign tx_fire = in_xfer && !fault && (wcnt < wlen_q) && !stat_dout_full
                   && tx_valid && !dout_prev;

  assign rx_accept = in_xfer && rx_valid_q && rx_ready;

  // A status clear loses to a TX write and is retried from clr_pend next cycle
  assign clr_want  = in_xfer && !fault && (clr_pend || rx_accept);
  assign status_rx = clr_want && !tx_fire;

  // Wait until the din_full clear has been written and seen by the core before
  // capturing again, otherwise the same byte would be taken twice
  assign rx_capture = in_xfer && !fault && stat_din_full && !rx_valid_q && !clr_pend
                      && !status_prev && (rcnt < rlen_q);

  assign progress = tx_fire || rx_accept || (flags != flags_prev);

  i2c_seq_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .enable (in_xfer),
    .clear  (progress),
    .expire (expire)
  );

  assign req_ready = (state == ST_IDLE);
  assign tx_ready  = tx_fire;
  assign rx_valid  = rx_valid_q;
  assign rx_data   = rx_data_q;
  assign done      = (state == ST_DONE);
  assign result    = res_q;

  // Register-interface drive: one write enable per cycle, decoded from state
  always_comb begin
    reg_wdata           = '0;
    reg_data_out_we     = 1'b0;
    reg_read_length_we  = 1'b0;
    reg_write_length_we = 1'b0;
    reg_clk_divider_we  = 1'b0;
    reg_config_we       = 1'b0;
    reg_status_we       = 1'b0;
    reg_start           = 1'b0;
    reg_packet_type     = 1'b0;
    reg_fifo_enable     = 1'b0;
    reg_status_wdata    = '0;
    case (state)
      ST_CFG_DIV: begin
        reg_clk_divider_we = 1'b1;
        reg_wdata          = {16'b0, clkdiv_q};
      end
      ST_CFG_WLEN: begin
        reg_write_length_we = 1'b1;
        reg_wdata           = 32'(wlen_q);
      end
      ST_CFG_RLEN: begin
        reg_read_length_we = 1'b1;
        reg_wdata          = 32'(rlen_q);
      end
      ST_CFG_START: begin
        reg_config_we   = 1'b1;
        reg_start       = 1'b1;
        reg_packet_type = ptype_q;
        reg_fifo_enable = 1'b0;
      end
      ST_XFER: begin
        if (tx_fire) begin
          reg_data_out_we = 1'b1;
          reg_wdata       = {24'b0, tx_data};
        end else if (status_rx) begin
          reg_status_we    = 1'b1;
          reg_status_wdata = status_rx_clear(stat_slave_nack, stat_dout_full, stat_stop);
        end
      end
      ST_CLEAR: begin
        reg_status_we = 1'b1;
      end
      default: ;
    endcase
  end

  // Transaction state, latched request, counters and the RX holding register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      wlen_q      <= '0;
      rlen_q      <= '0;
      clkdiv_q    <= '0;
      ptype_q     <= 1'b0;
      wcnt        <= '0;
      rcnt        <= '0;
      res_q       <= RES_OK;
      rx_valid_q  <= 1'b0;
      rx_data_q   <= '0;
      dout_prev   <= 1'b0;
      status_prev <= 1'b0;
      clr_pend    <= 1'b0;
      flags_prev  <= '0;
    end else begin
      dout_prev   <= tx_fire;
      status_prev <= status_rx;
      flags_prev  <= flags;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            wlen_q   <= req_wlen;
            rlen_q   <= req_rlen;
            clkdiv_q <= req_clkdiv;
            ptype_q  <= req_packet_type;
            wcnt     <= '0;
            rcnt     <= '0;
            clr_pend <= 1'b0;
            if ((req_wlen == '0) && (req_rlen == '0)) begin
              res_q <= RES_BAD_REQ;
              state <= ST_DONE;
            end else begin
              res_q <= RES_OK;
              state <= ST_CFG_DIV;
            end
          end
        end
        ST_CFG_DIV:   state <= ST_CFG_WLEN;
        ST_CFG_WLEN:  state <= ST_CFG_RLEN;
        ST_CFG_RLEN:  state <= ST_CFG_START;
        ST_CFG_START: state <= ST_XFER;
        ST_XFER: begin
          if (tx_fire) begin
            wcnt <= wcnt + CNT_W'(1);
          end
          if (rx_accept && (rcnt < rlen_q)) begin
            rcnt <= rcnt + CNT_W'(1);
          end
          if (rx_capture) begin
            rx_data_q  <= stat_data_in;
            rx_valid_q <= 1'b1;
          end else if (rx_accept) begin
            rx_valid_q <= 1'b0;
          end
          clr_pend <= clr_want && tx_fire;
          if (leave) begin
            if (stat_arb_loss) begin
              res_q <= RES_ARB_LOST;
            end else if (stat_slave_nack) begin
              res_q <= RES_NACK;
            end else if (expire) begin
              res_q <= RES_TIMEOUT;
            end else begin
              res_q <= RES_OK;
            end
            state <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          rx_valid_q <= 1'b0;
          clr_pend   <= 1'b0;
          state      <= ST_DONE;
        end
        ST_DONE: begin
          res_q <= RES_OK;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_transfer_sequencer.sv
// tb/tb_i2c_transfer_sequencer.sv - directed scoreboard bench for the I2C transfer sequencer
module tb_i2c_transfer_sequencer;

  localparam int TO = 16;

  localparam int K_DIV  = 1;
  localparam int K_WLEN = 2;
  localparam int K_RLEN = 3;
  localparam int K_CFG  = 4;
  localparam int K_DOUT = 5;
  localparam int K_STAT = 6;

  localparam int EV_ACC  = 0;
  localparam int EV_DONE = 1;
  localparam int EV_STAT = 2;
  localparam int EV_CFG  = 3;
  localparam int EV_DOUT = 4;

  typedef struct {
    int          kind;
    logic [31:0] data;
  } wr_t;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_wlen;
  logic [31:0] req_rlen;
  logic [15:0] req_clkdiv;
  logic        req_packet_type;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        done;
  logic [2:0]  result;
  logic [31:0] reg_wdata;
  logic        reg_data_out_we, reg_read_length_we, reg_write_length_we;
  logic        reg_clk_divider_we, reg_config_we, reg_status_we;
  logic        reg_start, reg_packet_type, reg_fifo_enable;
  logic [5:0]  reg_status_wdata;
  logic        stat_stop, stat_din_full, stat_dout_full, stat_slave_nack, stat_arb_loss;
  logic [7:0]  stat_data_in;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int cyc    = 0;

  wr_t        exp_q[$];
  logic [7:0] rx_q[$];

  logic [7:0] tx_base = 8'h00;
  int         tx_idx  = 0;
  int         done_cnt = 0;
  int         acc_cyc = 0;
  int         cfg_cyc = 0;
  int         ev_cyc  = 0;
  logic [2:0] ev_res  = '0;
  logic       dout_last = 1'b0;
  int         base_cyc = 0;

  assign tx_data = tx_base + tx_idx[7:0];

  i2c_transfer_sequencer #(
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (32)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_wlen            (req_wlen),
    .req_rlen            (req_rlen),
    .req_clkdiv          (req_clkdiv),
    .req_packet_type     (req_packet_type),
    .tx_valid            (tx_valid),
    .tx_data             (tx_data),
    .tx_ready            (tx_ready),
    .rx_valid            (rx_valid),
    .rx_data             (rx_data),
    .rx_ready            (rx_ready),
    .done                (done),
    .result              (result),
    .reg_wdata           (reg_wdata),
    .reg_data_out_we     (reg_data_out_we),
    .reg_read_length_we  (reg_read_length_we),
    .reg_write_length_we (reg_write_length_we),
    .reg_clk_divider_we  (reg_clk_divider_we),
    .reg_config_we       (reg_config_we),
    .reg_status_we       (reg_status_we),
    .reg_start           (reg_start),
    .reg_packet_type     (reg_packet_type),
    .reg_fifo_enable     (reg_fifo_enable),
    .reg_status_wdata    (reg_status_wdata),
    .stat_stop           (stat_stop),
    .stat_din_full       (stat_din_full),
    .stat_dout_full      (stat_dout_full),
    .stat_slave_nack     (stat_slave_nack),
    .stat_arb_loss       (stat_arb_loss),
    .stat_data_in        (stat_data_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_wr(input int kind, input logic [31:0] data);
    wr_t w;
    w.kind = kind;
    w.data = data;
    exp_q.push_back(w);
  endtask

  // Configuration sequence the sequencer must emit for a request
  task automatic push_cfg(input logic [15:0] cd, input logic [31:0] wl,
                          input logic [31:0] rl, input logic pt);
    push_wr(K_DIV, {16'b0, cd});
    push_wr(K_WLEN, wl);
    push_wr(K_RLEN, rl);
    push_wr(K_CFG, {29'b0, 1'b1, pt, 1'b0});
  endtask

  // Register-write, RX and done monitor; sampled on the falling edge
  always @(negedge clk) begin
    int   nwe;
    int   kind_obs;
    logic [31:0] data_obs;
    wr_t  e;
    if (reset) begin
      nwe = $countones({reg_data_out_we, reg_read_length_we, reg_write_length_we,
                        reg_clk_divider_we, reg_config_we, reg_status_we});
      kind_obs = 0;
      data_obs = reg_wdata;
      if (reg_clk_divider_we)       kind_obs = K_DIV;
      else if (reg_write_length_we) kind_obs = K_WLEN;
      else if (reg_read_length_we)  kind_obs = K_RLEN;
      else if (reg_config_we) begin
        kind_obs = K_CFG;
        data_obs = {29'b0, reg_start, reg_packet_type, reg_fifo_enable};
      end else if (reg_data_out_we) kind_obs = K_DOUT;
      else if (reg_status_we) begin
        kind_obs = K_STAT;
        data_obs = {26'b0, reg_status_wdata & 6'b101011};
      end
      if (nwe != 0) begin
        chk("one_we", 32'(nwe), 32'd1);
        if (exp_q.size() == 0) begin
          chk("wr_extra", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          chk("wr_kind", 32'(kind_obs), 32'(e.kind));
          chk("wr_data", data_obs, e.data);
        end
      end
      if (tx_ready || reg_data_out_we) begin
        chk("tx_ready_we", 32'(tx_ready), 32'(reg_data_out_we));
      end
      if (reg_data_out_we) begin
        chk("dout_gap", 32'(dout_last), 32'd0);
        tx_idx++;
      end
      if (rx_valid && rx_ready) begin
        if (rx_q.size() == 0) chk("rx_extra", 32'(rx_q.size()), 32'd1);
        else                  chk("rx_data", 32'(rx_data), 32'(rx_q.pop_front()));
      end
      if (req_valid && req_ready) acc_cyc = cyc;
      if (reg_config_we) cfg_cyc = cyc;
      if (done) done_cnt++;
      dout_last = reg_data_out_we;
    end else begin
      dout_last = 1'b0;
    end
  end

  // Wait (bounded) for a DUT event, then step to just after the next rising edge
  task automatic wait_ev(input int kind, input int budget);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      case (kind)
        EV_ACC:  hit = req_valid && req_ready;
        EV_DONE: hit = done;
        EV_STAT: hit = reg_status_we;
        EV_CFG:  hit = reg_config_we;
        default: hit = reg_data_out_we;
      endcase
      if (hit) begin
        ev_cyc = cyc;
        ev_res = result;
      end
    end
    chk("wait_event", 32'(hit), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tx(input int n, input int budget);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(posedge clk);
      hit = (tx_idx >= n);
    end
    chk("wait_tx", 32'(hit), 32'd1);
    #1;
  endtask

  task automatic send_req(input logic [31:0] wl, input logic [31:0] rl,
                          input logic [15:0] cd, input logic pt);
    req_wlen        = wl;
    req_rlen        = rl;
    req_clkdiv      = cd;
    req_packet_type = pt;
    req_valid       = 1'b1;
    wait_ev(EV_ACC, 20);
    req_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_ctrl"}, 32'({reg_data_out_we, reg_read_length_we, reg_write_length_we,
                             reg_clk_divider_we, reg_config_we, reg_status_we,
                             reg_start, reg_packet_type, reg_fifo_enable,
                             tx_ready, rx_valid, done}), 32'd0);
    chk({tag, "_wdata"}, reg_wdata, 32'd0);
    chk({tag, "_status_wdata"}, 32'(reg_status_wdata), 32'd0);
    chk({tag, "_result"}, 32'(result), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    req_valid = 1'b0; req_wlen = '0; req_rlen = '0; req_clkdiv = '0; req_packet_type = 1'b0;
    tx_valid = 1'b0; rx_ready = 1'b0;
    stat_stop = 1'b0; stat_din_full = 1'b0; stat_dout_full = 1'b0;
    stat_slave_nack = 1'b0; stat_arb_loss = 1'b0; stat_data_in = '0;
    #1;
    check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Write-only: 3 bytes, then stop
    tx_base = 8'h50; tx_idx = 0; tx_valid = 1'b1;
    push_cfg(16'h0040, 32'd3, 32'd0, 1'b0);
    push_wr(K_DOUT, 32'h50); push_wr(K_DOUT, 32'h51); push_wr(K_DOUT, 32'h52);
    push_wr(K_STAT, 32'h0);
    send_req(32'd3, 32'd0, 16'h0040, 1'b0);
    wait_tx(3, 40);
    tx_valid = 1'b0;
    stat_stop = 1'b1;
    wait_ev(EV_DONE, 20);
    chk("wr_result", 32'(ev_res), 32'd0);
    chk("wr_cfg_latency", 32'(cfg_cyc - acc_cyc), 32'd4);
    chk("wr_queue_empty", 32'(exp_q.size()), 32'd0);
    stat_stop = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Read-only: two bytes A5, 3C
    rx_ready = 1'b1;
    push_cfg(16'h0010, 32'd0, 32'd2, 1'b1);
    push_wr(K_STAT, 32'h0); push_wr(K_STAT, 32'h0); push_wr(K_STAT, 32'h0);
    rx_q.push_back(8'hA5); rx_q.push_back(8'h3C);
    send_req(32'd0, 32'd2, 16'h0010, 1'b1);
    stat_data_in = 8'hA5; stat_din_full = 1'b1;
    wait_ev(EV_STAT, 30);
    stat_data_in = 8'h3C;
    wait_ev(EV_STAT, 30);
    stat_din_full = 1'b0;
    stat_stop = 1'b1;
    wait_ev(EV_DONE, 20);
    chk("rd_result", 32'(ev_res), 32'd0);
    chk("rd_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("rd_rx_drained", 32'(rx_q.size()), 32'd0);
    stat_stop = 1'b0;
    rx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // NACK after the first of four bytes
    tx_base = 8'h20; tx_idx = 0; tx_valid = 1'b1;
    push_cfg(16'h0008, 32'd4, 32'd0, 1'b0);
    push_wr(K_DOUT, 32'h20);
    push_wr(K_STAT, 32'h0);
    send_req(32'd4, 32'd0, 16'h0008, 1'b0);
    wait_ev(EV_DOUT, 20);
    stat_slave_nack = 1'b1;
    wait_ev(EV_DONE, 20);
    chk("nack_result", 32'(ev_res), 32'd1);
    chk("nack_tx_count", 32'(tx_idx), 32'd1);
    chk("nack_queue_empty", 32'(exp_q.size()), 32'd0);
    stat_slave_nack = 1'b0; tx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Arbitration loss and NACK together: arbitration loss wins
    push_cfg(16'h0008, 32'd1, 32'd0, 1'b0);
    push_wr(K_STAT, 32'h0);
    send_req(32'd1, 32'd0, 16'h0008, 1'b0);
    wait_ev(EV_CFG, 20);
    stat_arb_loss = 1'b1; stat_slave_nack = 1'b1;
    wait_ev(EV_DONE, 20);
    chk("arb_result", 32'(ev_res), 32'd2);
    chk("arb_queue_empty", 32'(exp_q.size()), 32'd0);
    stat_arb_loss = 1'b0; stat_slave_nack = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Timeout: one byte written, core never stops. Counter reaches TO after TO idle
    // cycles, then one decision cycle, CLEAR and DONE follow.
    tx_base = 8'h77; tx_idx = 0; tx_valid = 1'b1;
    push_cfg(16'h0008, 32'd1, 32'd0, 1'b0);
    push_wr(K_DOUT, 32'h77);
    push_wr(K_STAT, 32'h0);
    send_req(32'd1, 32'd0, 16'h0008, 1'b0);
    wait_ev(EV_DOUT, 20);
    base_cyc = ev_cyc;
    tx_valid = 1'b0;
    wait_ev(EV_DONE, 40);
    chk("to_result", 32'(ev_res), 32'd3);
    chk("to_latency", 32'(ev_cyc - base_cyc), 32'(TO + 3));
    chk("to_queue_empty", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;

    // Empty request: done with BAD_REQ one cycle after acceptance, no writes
    send_req(32'd0, 32'd0, 16'h0008, 1'b0);
    wait_ev(EV_DONE, 10);
    chk("bad_result", 32'(ev_res), 32'd4);
    chk("bad_latency", 32'(ev_cyc - acc_cyc), 32'd1);
    repeat (2) @(posedge clk);
    #1;

    // Reset in the middle of XFER
    push_cfg(16'h0008, 32'd2, 32'd0, 1'b0);
    send_req(32'd2, 32'd0, 16'h0008, 1'b0);
    wait_ev(EV_CFG, 20);
    base_cyc = done_cnt;
    reset = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("midrst_no_done", 32'(done_cnt), 32'(base_cyc));
    chk("midrst_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("midrst_idle", 32'(req_ready), 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
